prog_loader: RTL and testbench

Boot-time program loader between the UART receiver and the program BRAM write port. It assembles received bytes into 16-bit big-endian instruction words and writes them to consecutive program addresses from 0. It detects the word-aligned end marker 16'hFFFF, then releases the CPU by raising `cpu_run` and reports the load result as one byte for the UART transmitter. An inter-byte timeout resynchronises byte pairing, so a lost byte cannot permanently shift every following instruction.

---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: UART receive, program BRAM write and load-status signals of the boot loader.
// The loader uses the slave modport; the UART/BRAM/CPU side uses the master modport.
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_data_wr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_run;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        ack_data;
    logic              ack_en;

    modport slave (
        input  rx_data, rx_data_wr,
        output wr_en, wr_addr, wr_data, cpu_run, word_count, ack_data, ack_en
    );

    modport master (
        output rx_data, rx_data_wr,
        input  wr_en, wr_addr, wr_data, cpu_run, word_count, ack_data, ack_en
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: pairs UART bytes into big-endian words and writes them to program BRAM.
// The load ends on a word-aligned FFFF marker, which releases the CPU and reports a result byte.
module prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 2700000
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    prog_loader_if.slave  bus_if
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {WAIT_HI, WAIT_LO, RUN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic              ovf_q, ovf_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              cpu_run_q, cpu_run_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [7:0]        ack_data_q, ack_data_d;
    logic              ack_en_q, ack_en_d;
    logic [15:0]       word;

    assign word = {hi_q, bus_if.rx_data};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_HI;
            hi_q       <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_run_q  <= 1'b0;
            wc_q       <= '0;
            ack_data_q <= '0;
            ack_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_run_q  <= cpu_run_d;
            wc_q       <= wc_d;
            ack_data_q <= ack_data_d;
            ack_en_q   <= ack_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        // the address advances the cycle after a write pulse, so the pulse sees the current slot
        wr_addr_d  = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;
        cpu_run_d  = cpu_run_q;
        wc_d       = wc_q;
        ack_data_d = ack_data_q;
        ack_en_d   = 1'b0;
        case (state_q)
            WAIT_HI: begin
                if (bus_if.rx_data_wr) begin
                    hi_d    = bus_if.rx_data;
                    tmo_d   = '0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (bus_if.rx_data_wr) begin
                    state_d = WAIT_HI;
                    if (word == 16'hFFFF) begin
                        ack_en_d = 1'b1;
                        if (!ovf_q) begin
                            state_d    = RUN;
                            cpu_run_d  = 1'b1;
                            ack_data_d = 8'(wc_q);
                        end else begin
                            ack_data_d = 8'hEE;
                            ovf_d      = 1'b0;
                            wc_d       = '0;
                            wr_addr_d  = '0;
                        end
                    end else if (!wc_q[ADDR_W]) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word;
                        wc_d      = wc_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = WAIT_HI;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RUN: begin
                if (bus_if.rx_data_wr) begin
                    cpu_run_d = 1'b0;
                    wr_addr_d = '0;
                    wc_d      = '0;
                    ovf_d     = 1'b0;
                    hi_d      = bus_if.rx_data;
                    tmo_d     = '0;
                    state_d   = WAIT_LO;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    assign bus_if.wr_en      = wr_en_q;
    assign bus_if.wr_addr    = wr_addr_q;
    assign bus_if.wr_data    = wr_data_q;
    assign bus_if.cpu_run    = cpu_run_q;
    assign bus_if.word_count = wc_q;
    assign bus_if.ack_data   = ack_data_q;
    assign bus_if.ack_en     = ack_en_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed byte streams with a write/ack scoreboard for prog_loader.
module tb_prog_loader;
    localparam int AW  = 2;
    localparam int TMO = 20;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] exp_wr[$];
    logic [31:0] obs_wr[$];
    logic [7:0]  exp_ack[$];
    logic [7:0]  obs_ack[$];

    prog_loader_if #(.ADDR_W(AW)) bus ();
    prog_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (bus.wr_en) obs_wr.push_back((32'(bus.wr_addr) << 16) | 32'(bus.wr_data));
        if (bus.ack_en) obs_ack.push_back(bus.ack_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge sys_clk);
        bus.rx_data    = b;
        bus.rx_data_wr = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.rx_data_wr = 1'b0;
    endtask

    task automatic pair(input logic [7:0] h, input logic [7:0] l);
        send(h);
        idle(3);
        send(l);
        idle(3);
    endtask

    task automatic exp_w(input int a, input logic [15:0] d);
        exp_wr.push_back((32'(a) << 16) | 32'(d));
    endtask

    task automatic marker(input logic run);
        send(8'hFF);
        idle(3);
        send(8'hFF);
        chk("marker_ack_en", 32'(bus.ack_en), 32'd1);
        chk("marker_cpu_run", 32'(bus.cpu_run), 32'(run));
        idle(3);
    endtask

    task automatic drain(input string tag);
        idle(4);
        chk({tag, "_nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
        while (exp_wr.size() > 0 && obs_wr.size() > 0)
            chk({tag, "_wr"}, obs_wr.pop_front(), exp_wr.pop_front());
        chk({tag, "_nack"}, 32'(obs_ack.size()), 32'(exp_ack.size()));
        while (exp_ack.size() > 0 && obs_ack.size() > 0)
            chk({tag, "_ack"}, 32'(obs_ack.pop_front()), 32'(exp_ack.pop_front()));
        exp_wr.delete();
        obs_wr.delete();
        exp_ack.delete();
        obs_ack.delete();
    endtask

    initial begin
        bus.rx_data    = 8'h00;
        bus.rx_data_wr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {bus.wr_en, bus.cpu_run, bus.ack_en, 5'(bus.word_count), bus.ack_data, 2'(bus.wr_addr)}, 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // normal load
        exp_w(0, 16'h1234);
        exp_w(1, 16'hABCD);
        exp_ack.push_back(8'h02);
        pair(8'h12, 8'h34);
        pair(8'hAB, 8'hCD);
        chk("normal_pre_run", 32'(bus.cpu_run), 32'd0);
        marker(1'b1);
        chk("normal_wc", 32'(bus.word_count), 32'd2);
        drain("normal");

        // FF bytes straddling word boundaries are data, not markers
        exp_w(0, 16'h12FF);
        exp_w(1, 16'hFF34);
        exp_ack.push_back(8'h02);
        send(8'h12);
        chk("reload_drop", 32'(bus.cpu_run), 32'd0);
        idle(3);
        send(8'hFF);
        idle(3);
        pair(8'hFF, 8'h34);
        chk("misalign_no_run", 32'(bus.cpu_run), 32'd0);
        marker(1'b1);
        drain("misalign");

        // lone high byte dropped by timeout
        exp_w(0, 16'h5678);
        exp_ack.push_back(8'h01);
        send(8'h12);
        idle(TMO + 5);
        chk("tmo_wc", 32'(bus.word_count), 32'd0);
        pair(8'h56, 8'h78);
        marker(1'b1);
        chk("tmo_wc_end", 32'(bus.word_count), 32'd1);
        drain("timeout");

        // overflow: fifth word rejected, marker reports EE
        for (int i = 0; i < 4; i++) exp_w(i, 16'h1000 + 16'(i));
        exp_ack.push_back(8'hEE);
        for (int i = 0; i < 5; i++) pair(8'h10, 8'(i));
        chk("ovf_wc", 32'(bus.word_count), 32'd4);
        marker(1'b0);
        chk("ovf_wc_clr", 32'(bus.word_count), 32'd0);
        chk("ovf_addr_clr", 32'(bus.wr_addr), 32'd0);
        drain("overflow");
        exp_w(0, 16'h0001);
        exp_ack.push_back(8'h01);
        pair(8'h00, 8'h01);
        marker(1'b1);
        drain("ovf_retry");

        // reload from RUN
        exp_w(0, 16'h9ABC);
        exp_ack.push_back(8'h01);
        send(8'h9A);
        chk("reload_run_low", 32'(bus.cpu_run), 32'd0);
        idle(3);
        send(8'hBC);
        idle(3);
        marker(1'b1);
        drain("reload");

        // async reset between the bytes of a pair
        exp_w(0, 16'h1122);
        pair(8'h11, 8'h22);
        send(8'h33);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wc", 32'(bus.word_count), 32'd0);
        chk("arst_ack", 32'(bus.ack_data), 32'd0);
        chk("arst_run", 32'(bus.cpu_run), 32'd0);
        idle(2);
        rst_n = 1'b1;
        drain("pre_arst");
        exp_w(0, 16'h4455);
        exp_ack.push_back(8'h01);
        pair(8'h44, 8'h55);
        marker(1'b1);
        drain("post_arst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
